// File: rtl/ex_mem_pipe.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe
//
// Pipeline register between the execute and memory stages. DEPTH chained
// slots carry a valid bit and an opaque payload. A side-state word, tied to
// the last slot, is fed back to EX so that multi-cycle operations keep their
// progress across their own stall. A saturating counter records how many
// bubbles the last slot has inserted.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous active-low reset
//   stall        global stall vector (1 = stall); slot k owns STALL_BASE+k
//   flush        synchronous clear of every slot and the side state
//   in_valid     valid bit of the EX result
//   in_payload   EX result payload (all zero is a NOP)
//   state_i      side state from EX (HI/LO accumulator + cycle count)
//   out_valid    valid bit of the last slot
//   out_payload  payload of the last slot
//   state_o      registered side state returned to EX
//   bubble_cnt   saturating count of bubbles inserted by the last slot
//   cnt_clr      synchronous clear of bubble_cnt (wins over an increment)
// ---------------------------------------------------------------------------
module ex_mem_pipe #(
    parameter int PAY_W      = 175,
    parameter int STATE_W    = 66,
    parameter int DEPTH      = 1,
    parameter int STALL_W    = 6,
    parameter int STALL_BASE = 3,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [PAY_W-1:0]   in_payload,
    input  logic [STATE_W-1:0] state_i,
    input  logic               cnt_clr,
    output logic               out_valid,
    output logic [PAY_W-1:0]   out_payload,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int L = DEPTH - 1;

    // Elaboration-time sanity checks on the configuration.
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("ex_mem_pipe: DEPTH must be in 1..4");
    end
    if (STALL_BASE + DEPTH > STALL_W - 1) begin : g_bad_stall
        $error("ex_mem_pipe: STALL_BASE+DEPTH must not exceed STALL_W-1");
    end

    // Only a window of the global stall vector belongs to this stage; the
    // rest is deliberately ignored.
    logic stall_unused;
    assign stall_unused = ^stall;

    // Flattened view of every slot so that slot k+1 can read slot k.
    logic [DEPTH-1:0]            slot_valid;
    logic [DEPTH-1:0][PAY_W-1:0] slot_payload;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic             src_valid;
        logic [PAY_W-1:0] src_payload;
        logic             own_stall;
        logic             next_stall;
        logic             valid_q;
        logic             valid_d;
        logic [PAY_W-1:0] payload_q;
        logic [PAY_W-1:0] payload_d;

        if (gi == 0) begin : g_head
            assign src_valid   = in_valid;
            assign src_payload = in_payload;
        end else begin : g_chain
            assign src_valid   = slot_valid[gi-1];
            assign src_payload = slot_payload[gi-1];
        end

        assign own_stall  = stall[STALL_BASE+gi];
        assign next_stall = stall[STALL_BASE+gi+1];

        // Flush beats everything; a stalled slot with a free consumer emits
        // a NOP bubble; an unstalled slot captures its input (payload is
        // taken even when invalid); otherwise the slot holds.
        always_comb begin
            valid_d   = valid_q;
            payload_d = payload_q;
            if (flush) begin
                valid_d   = 1'b0;
                payload_d = '0;
            end else if (own_stall && !next_stall) begin
                valid_d   = 1'b0;
                payload_d = '0;
            end else if (!own_stall) begin
                valid_d   = src_valid;
                payload_d = src_payload;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q   <= 1'b0;
                payload_q <= '0;
            end else begin
                valid_q   <= valid_d;
                payload_q <= payload_d;
            end
        end

        assign slot_valid[gi]   = valid_q;
        assign slot_payload[gi] = payload_q;
    end

    assign out_valid   = slot_valid[L];
    assign out_payload = slot_payload[L];

    // ------------------------------------------------------------------
    // Side state and bubble counter, both tied to the last slot.
    // ------------------------------------------------------------------
    logic               last_own;
    logic               last_next;
    logic               last_bubble;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    assign last_own    = stall[STALL_BASE+L];
    assign last_next   = stall[STALL_BASE+L+1];
    assign last_bubble = last_own && !last_next && !flush;

    always_comb begin
        // While the last slot is stalled the multi-cycle op is still in
        // flight, so its progress is looped back; once it moves on, clear.
        state_d = '0;
        if (!flush && last_own) begin
            state_d = state_i;
        end

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (last_bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o    = state_q;
    assign bubble_cnt = cnt_q;

endmodule
